muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide instructions.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake and raises a stall request while busy.
- Returns the result with its rd address through a second valid/ready handshake.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiply latency in cycles from acceptance to out_valid (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept operation this cycle
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  input  XLEN  dividend / multiplicand
rs2_data  input  XLEN  divisor / multiplier
rd_in  input  5  destination register address
flush  input  1  discard in-flight operation
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  XLEN  operation result
rd_out  output  5  rd address of result
busy  output  1  stall request to pipeline (state != IDLE and result not yet taken)

Behaviour:
- Reset: state IDLE.
  - out_valid, result, rd_out and busy are 0.
  - in_ready is 0 while rst is high and 1 from the first cycle after.
- FSM states: IDLE, MUL, DIV, DONE.
- Acceptance: occurs at an edge where in_valid && in_ready.
  - in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
  - The DONE-state term allows back-to-back operations with no bubble.
- Operand latching: op, rs1_data, rs2_data and rd_in are latched at acceptance and ignored afterwards.
- Multiply:
  - Computes the full 2*XLEN product, with operand signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - out_valid rises MUL_STAGES cycles after the acceptance edge.
  - A cycle counter tracks the latency; the product may be pipelined.
- Divide special cases: resolve in 1 cycle (out_valid the cycle after acceptance).
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = -1): DIV returns rs1; REM returns 0.
- Divide normal case: radix-2 restoring division on magnitudes.
  - Performs XLEN iterations, one per cycle, then applies sign correction.
  - Quotient is negative iff operand signs differ; remainder takes the dividend's sign.
  - out_valid rises XLEN+1 cycles after acceptance.
- DONE state:
  - result and rd_out are stable and out_valid is held high until out_ready.
  - On out_ready without a new acceptance: go to IDLE; out_valid drops next cycle.
  - On out_ready with a new acceptance: go directly to MUL or DIV.
- Flush:
  - Takes priority over everything except rst.
  - Next state is IDLE and out_valid is 0 next cycle.
  - No acceptance occurs in the flush cycle.
  - Counters are cleared; result is don't-care.
- Reset mid-operation: same as flush, and all outputs return to reset values.
- busy: high in MUL and DIV, and in DONE while !out_ready.
- Unused input changes while busy have no effect.

Test Plan:
- MUL, XLEN=32: rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB after exactly 2 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH: 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; rd_out equals the latched rd_in=5.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100/7 -> 14 and REMU -> 2; each out_valid exactly 33 cycles after acceptance.
- Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF and REMU -> 0x1234 in 1 cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0 in 1 cycle.
- Backpressure and back-to-back:
  - out_ready low 5 cycles -> result stable and busy high throughout.
  - Raise out_ready with in_valid high -> next op accepted the same edge with no idle cycle.
- Flush at divide cycle 10, and rst at multiply cycle 1 -> out_valid never asserts, IDLE next cycle; a subsequent MUL 3*4 returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Multiplies take MUL_STAGES cycles; divides use radix-2 restoring iteration.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN + 2);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, bmag_q, bmag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic              accept;
  logic              in_signed;
  logic [XLEN-1:0]   in_amag, in_bmag;
  logic              a_sext, b_sext;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN:0]     shifted, diff;
  logic              div_by_zero, div_ovf;

  assign in_ready = !rst && !flush && (state_q == StIdle || (state_q == StDone && out_ready));
  assign accept   = in_valid && in_ready;

  // DIV and REM (even funct3 within the divide group) are the signed divides.
  assign in_signed = !op[0];
  assign in_amag   = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
  assign in_bmag   = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

  // MULH/MULHSU sign-extend rs1; only MULH sign-extends rs2.
  assign a_sext = (op_q[1:0] == 2'd1) || (op_q[1:0] == 2'd2);
  assign b_sext = (op_q[1:0] == 2'd1);
  assign a_ext  = {{XLEN{a_sext & a_q[XLEN-1]}}, a_q};
  assign b_ext  = {{XLEN{b_sext & b_q[XLEN-1]}}, b_q};
  assign prod   = a_ext * b_ext;

  assign shifted     = {rem_q, quo_q[XLEN-1]};
  assign diff        = shifted - {1'b0, bmag_q};
  assign div_by_zero = (b_q == '0);
  assign div_ovf     = !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    bmag_d   = bmag_q;
    result_d = result_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: ;
      StMul: begin
        if (cnt_q == CntW'(MUL_STAGES - 1)) begin
          result_d = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          rd_out_d = rd_q;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (cnt_q == '0 && (div_by_zero || div_ovf)) begin
          if (div_by_zero) result_d = op_q[1] ? a_q : '1;
          else             result_d = op_q[1] ? '0 : a_q;
          rd_out_d = rd_q;
          state_d  = StDone;
        end else if (cnt_q == CntW'(XLEN)) begin
          if (op_q[1]) result_d = rneg_q ? -rem_q : rem_q;
          else         result_d = qneg_q ? -quo_q : quo_q;
          rd_out_d = rd_q;
          state_d  = StDone;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d    = op;
      a_d     = rs1_data;
      b_d     = rs2_data;
      rd_d    = rd_in;
      cnt_d   = '0;
      quo_d   = in_amag;
      rem_d   = '0;
      bmag_d  = in_bmag;
      qneg_d  = in_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
      rneg_d  = in_signed && rs1_data[XLEN-1];
      state_d = op[2] ? StDiv : StMul;
    end

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      bmag_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign busy      = (state_q == StMul) || (state_q == StDiv) ||
                     (state_q == StDone && !out_ready);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected {rd, result} pairs are queued at issue
// and popped when out_valid appears.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data, rs2_data, result;
  logic [4:0]      rd_in, rd_out;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] sb_q[$];
  logic        seen;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .rd_out   (rd_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic push, input logic [31:0] exp);
    in_valid = 1'b1;
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    #1;
    chk("in_ready_at_issue", 64'(in_ready), 64'd1);
    if (push) sb_q.push_back({rd, exp});
    tick();
    // Operands must be ignored after acceptance.
    in_valid = 1'b0;
    op       = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
  endtask

  task automatic await_result(input string tag, input int exp_lat);
    int          lat;
    logic [36:0] e;
    lat = 0;
    e   = '1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk({tag, "_result"}, 64'(result), 64'(e[31:0]));
    chk({tag, "_rd"}, 64'(rd_out), 64'(e[36:32]));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    rd_in     = '0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Multiplies
    send(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1, 32'hFFFF_FFEB);
    chk("mul_busy", 64'(busy), 64'd1);
    await_result("mul", 2);
    tick();
    chk("mul_drop", 64'(out_valid), 64'd0);
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'hFFFF_FFFE);
    await_result("mulhu", 2);
    tick();
    send(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b1, 32'h4000_0000);
    await_result("mulh", 2);
    tick();
    send(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFF);
    await_result("mulhsu", 2);
    tick();

    // Normal divides
    send(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFD);
    await_result("div", 33);
    tick();
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFF);
    await_result("rem", 33);
    tick();
    send(3'd5, 32'd100, 32'd7, 5'd8, 1'b1, 32'd14);
    await_result("divu", 33);
    tick();
    send(3'd7, 32'd100, 32'd7, 5'd9, 1'b1, 32'd2);
    await_result("remu", 33);
    tick();

    // Divide special cases
    send(3'd5, 32'h1234, 32'd0, 5'd10, 1'b1, 32'hFFFF_FFFF);
    await_result("divu_zero", 1);
    tick();
    send(3'd7, 32'h1234, 32'd0, 5'd11, 1'b1, 32'h1234);
    await_result("remu_zero", 1);
    tick();
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h8000_0000);
    await_result("div_ovf", 1);
    tick();
    send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'd0);
    await_result("rem_ovf", 1);
    tick();

    // Backpressure then back-to-back issue from the held result
    out_ready = 1'b0;
    send(3'd0, 32'd6, 32'd7, 5'd14, 1'b1, 32'd42);
    await_result("bp", 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(result), 64'd42);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    send(3'd0, 32'd9, 32'd9, 5'd15, 1'b1, 32'd81);
    chk("b2b_no_bubble_busy", 64'(busy), 64'd1);
    chk("b2b_valid_low", 64'(out_valid), 64'd0);
    await_result("b2b", 2);
    tick();

    // Flush in the middle of a divide
    send(3'd5, 32'd100, 32'd7, 5'd16, 1'b0, 32'd0);
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_idle_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_never_valid", 64'(seen), 64'd0);

    // Reset during the first multiply cycle
    send(3'd0, 32'd3, 32'd5, 5'd17, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_rd_out", 64'(rd_out), 64'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_never_valid", 64'(seen), 64'd0);
    send(3'd0, 32'd3, 32'd4, 5'd18, 1'b1, 32'd12);
    await_result("mul_after_rst", 2);
    tick();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
